// File: rtl/aftab_div_pkg.sv
// Shared encodings and helpers for the AFTAB AAU radix-2^K restoring divider.
package aftab_div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } divOp_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_ITER = 2'b10,
        S_DONE = 2'b11
    } divState_e;

    // Bit 0 of the op marks an unsigned variant, bit 1 selects the remainder.
    function automatic logic isSignedOp(input divOp_e op);
        return !op[0];
    endfunction

    function automatic logic isRemOp(input divOp_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/aftab_rv_divider_if.sv
// Request/response bundle between the AAU controller and the divider.
interface aftab_rv_divider_if #(
    parameter int unsigned WIDTH = 32
) ();
    import aftab_div_pkg::*;

    logic             startDiv;
    logic             abortDiv;
    divOp_e           op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             readyDiv;
    logic             doneDiv;
    logic [WIDTH-1:0] result;
    logic             divByZero;
    logic             overflow;

    modport master (
        output startDiv, abortDiv, op, dividend, divisor,
        input  readyDiv, doneDiv, result, divByZero, overflow
    );

    modport slave (
        input  startDiv, abortDiv, op, dividend, divisor,
        output readyDiv, doneDiv, result, divByZero, overflow
    );
endinterface

// File: rtl/aftab_div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial subtract, restore on borrow.
module aftab_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   remNext,
    output logic [WIDTH-1:0] quoNext
);
    logic [WIDTH:0] remShift;
    logic [WIDTH:0] trial;

    // The remainder never exceeds the divisor, so dropping its top bit on the shift is lossless.
    always_comb begin
        remShift = (WIDTH+1)'({rem, quo[WIDTH-1]});
        trial    = remShift - {1'b0, dvs};
        remNext  = trial[WIDTH] ? remShift : trial;
        quoNext  = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end
endmodule

// File: rtl/aftab_rv_divider.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit with ready/start/done handshake and abort.
module aftab_rv_divider
    import aftab_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned K     = 1
) (
    input logic               clk,
    input logic               rst,
    aftab_rv_divider_if.slave divIf
);
    localparam int unsigned    ITERS   = WIDTH / K;
    localparam int unsigned    CNT_W   = $clog2(ITERS);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    divState_e        state;
    divOp_e           opR;
    logic [WIDTH-1:0] dvdR;
    logic [WIDTH-1:0] dvsR;
    logic [WIDTH-1:0] quoR;
    logic [WIDTH:0]   remR;
    logic [CNT_W-1:0] cnt;
    logic             signQ;
    logic             signR;
    logic             readyR;
    logic             doneR;
    logic [WIDTH-1:0] resultR;
    logic             dbzR;
    logic             ovfR;

    logic             sd;
    logic             sv;
    logic             divZero;
    logic             divOvf;
    logic [WIDTH-1:0] magDvd;
    logic [WIDTH-1:0] magDvs;
    logic [WIDTH-1:0] quoFin;
    logic [WIDTH-1:0] remFin;
    logic [WIDTH-1:0] quoOut;
    logic [WIDTH-1:0] remOut;

    logic [WIDTH:0]   remChain [K+1];
    logic [WIDTH-1:0] quoChain [K+1];

    // Sign/magnitude and special-case detection on the raw operands held during PREP.
    always_comb begin
        sd      = isSignedOp(opR) & dvdR[WIDTH-1];
        sv      = isSignedOp(opR) & dvsR[WIDTH-1];
        magDvd  = sd ? (~dvdR + WIDTH'(1)) : dvdR;
        magDvs  = sv ? (~dvsR + WIDTH'(1)) : dvsR;
        divZero = (dvsR == '0);
        divOvf  = isSignedOp(opR) && (dvdR == MIN_NEG) && (dvsR == '1);
    end

    assign remChain[0] = remR;
    assign quoChain[0] = quoR;

    for (genvar i = 0; i < K; i++) begin : gStep
        aftab_div_step #(.WIDTH(WIDTH)) uStep (
            .rem     (remChain[i]),
            .quo     (quoChain[i]),
            .dvs     (dvsR),
            .remNext (remChain[i+1]),
            .quoNext (quoChain[i+1])
        );
    end

    always_comb begin
        quoFin = quoChain[K];
        remFin = remChain[K][WIDTH-1:0];
        quoOut = signQ ? (~quoFin + WIDTH'(1)) : quoFin;
        remOut = signR ? (~remFin + WIDTH'(1)) : remFin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            opR     <= OP_DIV;
            dvdR    <= '0;
            dvsR    <= '0;
            quoR    <= '0;
            remR    <= '0;
            cnt     <= '0;
            signQ   <= 1'b0;
            signR   <= 1'b0;
            readyR  <= 1'b1;
            doneR   <= 1'b0;
            resultR <= '0;
            dbzR    <= 1'b0;
            ovfR    <= 1'b0;
        end else begin
            doneR <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (divIf.startDiv && !divIf.abortDiv) begin
                        opR    <= divIf.op;
                        dvdR   <= divIf.dividend;
                        dvsR   <= divIf.divisor;
                        readyR <= 1'b0;
                        state  <= S_PREP;
                    end else begin
                        readyR <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (divIf.abortDiv) begin
                        readyR <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        signQ <= sd ^ sv;
                        signR <= sd;
                        quoR  <= magDvd;
                        dvsR  <= magDvs;
                        remR  <= '0;
                        cnt   <= '0;
                        dbzR  <= divZero;
                        ovfR  <= divOvf && !divZero;
                        if (divZero) begin
                            resultR <= isRemOp(opR) ? dvdR : '1;
                            doneR   <= 1'b1;
                            readyR  <= 1'b1;
                            state   <= S_DONE;
                        end else if (divOvf) begin
                            resultR <= isRemOp(opR) ? '0 : dvdR;
                            doneR   <= 1'b1;
                            readyR  <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    if (divIf.abortDiv) begin
                        readyR <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        quoR <= quoChain[K];
                        remR <= remChain[K];
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ITERS - 1)) begin
                            resultR <= isRemOp(opR) ? remOut : quoOut;
                            doneR   <= 1'b1;
                            readyR  <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                default: begin
                    readyR <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign divIf.readyDiv  = readyR;
    assign divIf.doneDiv   = doneR;
    assign divIf.result    = resultR;
    assign divIf.divByZero = dbzR;
    assign divIf.overflow  = ovfR;
endmodule

// File: tb/tb_aftab_rv_divider.sv
// Directed checks of the divider at K=1 and K=2 (WIDTH=32): results, flags, latency and handshake corners.
module tb_aftab_rv_divider;
    import aftab_div_pkg::*;

    typedef struct {
        divOp_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        logic        expDbz;
        logic        expOvf;
        int          expLat1;
        int          expLat2;
    } vec_t;

    localparam int unsigned NVEC = 20;

    logic        clk;
    logic        rst;
    logic        startS;
    logic        abortS;
    divOp_e      opS;
    logic [31:0] dvdS;
    logic [31:0] dvsS;

    int          nTests;
    int          nFail;
    int          lat1;
    int          lat2;
    logic [31:0] res1;
    logic [31:0] res2;
    logic        dbz1;
    logic        ovf1;
    vec_t        vecs [NVEC];

    aftab_rv_divider_if #(.WIDTH(32)) ifK1 ();
    aftab_rv_divider_if #(.WIDTH(32)) ifK2 ();

    assign ifK1.startDiv = startS;
    assign ifK1.abortDiv = abortS;
    assign ifK1.op       = opS;
    assign ifK1.dividend = dvdS;
    assign ifK1.divisor  = dvsS;
    assign ifK2.startDiv = startS;
    assign ifK2.abortDiv = abortS;
    assign ifK2.op       = opS;
    assign ifK2.dividend = dvdS;
    assign ifK2.divisor  = dvsS;

    aftab_rv_divider #(.WIDTH(32), .K(1)) dutK1 (.clk(clk), .rst(rst), .divIf(ifK1));
    aftab_rv_divider #(.WIDTH(32), .K(2)) dutK2 (.clk(clk), .rst(rst), .divIf(ifK2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request for one cycle (cycle 0); returns at cycle 1.
    task automatic startOp(input divOp_e o, input logic [31:0] a, input logic [31:0] b);
        opS    = o;
        dvdS   = a;
        dvsS   = b;
        startS = 1'b1;
        step();
        startS = 1'b0;
    endtask

    // Bounded wait for a K=1 doneDiv pulse; lat = -1 on timeout.
    task automatic waitDone(input int c0, output int lat);
        lat = -1;
        for (int c = c0; c <= c0 + 60; c++) begin
            if (ifK1.doneDiv) begin
                lat = c;
                break;
            end
            step();
        end
    endtask

    task automatic countDone(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            if (ifK1.doneDiv || ifK2.doneDiv) n++;
            step();
        end
    endtask

    // Issue one op to both units and record each unit's done latency and outputs.
    task automatic runOp(input divOp_e o, input logic [31:0] a, input logic [31:0] b);
        startOp(o, a, b);
        lat1 = -1;
        lat2 = -1;
        for (int c = 1; c <= 60; c++) begin
            if (ifK1.doneDiv && lat1 < 0) begin
                lat1 = c;
                res1 = ifK1.result;
                dbz1 = ifK1.divByZero;
                ovf1 = ifK1.overflow;
            end
            if (ifK2.doneDiv && lat2 < 0) begin
                lat2 = c;
                res2 = ifK2.result;
            end
            if (lat1 >= 0 && lat2 >= 0) break;
            step();
        end
    endtask

    initial begin
        int          lat;
        int          n;
        logic [31:0] prevRes;

        nTests = 0;
        nFail  = 0;
        res1   = '0;
        res2   = '0;
        dbz1   = 1'b0;
        ovf1   = 1'b0;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0, 34, 18};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0, 1'b0, 34, 18};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 1'b0, 34, 18};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0, 34, 18};
        vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 1'b0, 34, 18};
        vecs[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 1'b0, 34, 18};
        vecs[6]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0, 2,  2};
        vecs[7]  = '{OP_REM,  32'd5,          32'd0,          32'd5,          1'b1, 1'b0, 2,  2};
        vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b1, 2,  2};
        vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b1, 2,  2};
        vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 34, 18};
        vecs[11] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, 1'b0, 34, 18};
        vecs[12] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b0, 34, 18};
        vecs[13] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 34, 18};
        vecs[14] = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0, 1'b0, 34, 18};
        vecs[15] = '{OP_DIV,  32'd0,          32'd5,          32'd0,          1'b0, 1'b0, 34, 18};
        vecs[16] = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0, 2,  2};
        vecs[17] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, 1'b0, 34, 18};
        vecs[18] = '{OP_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  1'b0, 1'b0, 34, 18};
        vecs[19] = '{OP_REMU, 32'hDEAD_BEEF,  32'h10,         32'hF,          1'b0, 1'b0, 34, 18};

        rst    = 1'b1;
        startS = 1'b0;
        abortS = 1'b0;
        opS    = OP_DIV;
        dvdS   = '0;
        dvsS   = '0;
        step();
        step();
        check("reset readyDiv", 32'(ifK1.readyDiv), 32'd1);
        check("reset doneDiv", 32'(ifK1.doneDiv), 32'd0);
        check("reset result", ifK1.result, 32'd0);
        check("reset flags", {30'd0, ifK1.divByZero, ifK1.overflow}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < int'(NVEC); i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d K1 latency", i), 32'(lat1), 32'(vecs[i].expLat1));
            check($sformatf("vec%0d K1 result", i), res1, vecs[i].expRes);
            check($sformatf("vec%0d divByZero", i), 32'(dbz1), 32'(vecs[i].expDbz));
            check($sformatf("vec%0d overflow", i), 32'(ovf1), 32'(vecs[i].expOvf));
            check($sformatf("vec%0d K2 latency", i), 32'(lat2), 32'(vecs[i].expLat2));
            check($sformatf("vec%0d K2 result", i), res2, vecs[i].expRes);
        end
        step();
        step();

        // Abort at cycle 10: no done, ready next cycle, result untouched.
        prevRes = ifK1.result;
        startOp(OP_DIVU, 32'd100, 32'd7);
        for (int c = 1; c < 10; c++) step();
        abortS = 1'b1;
        step();
        abortS = 1'b0;
        check("abort readyDiv", 32'(ifK1.readyDiv), 32'd1);
        check("abort doneDiv", 32'(ifK1.doneDiv), 32'd0);
        check("abort result held", ifK1.result, prevRes);
        countDone(40, n);
        check("abort stray done", 32'(n), 32'd0);

        // Start while busy is dropped.
        startOp(OP_DIVU, 32'd100, 32'd7);
        for (int c = 1; c < 5; c++) step();
        check("busy readyDiv", 32'(ifK1.readyDiv), 32'd0);
        startOp(OP_DIVU, 32'd200, 32'd1);
        waitDone(6, lat);
        check("busy latency", 32'(lat), 32'd34);
        check("busy result", ifK1.result, 32'd14);
        step();
        countDone(40, n);
        check("busy extra done", 32'(n), 32'd0);

        // Back-to-back accept in DONE.
        startOp(OP_DIVU, 32'd100, 32'd7);
        waitDone(1, lat);
        check("b2b first latency", 32'(lat), 32'd34);
        startOp(OP_REMU, 32'd100, 32'd7);
        check("b2b done pulse width", 32'(ifK1.doneDiv), 32'd0);
        waitDone(1, lat);
        check("b2b second latency", 32'(lat), 32'd34);
        check("b2b second result", ifK1.result, 32'd2);
        step();

        // Flag and result hold after a divide-by-zero.
        startOp(OP_DIVU, 32'd5, 32'd0);
        waitDone(1, lat);
        check("dbz latency", 32'(lat), 32'd2);
        step();
        check("hold doneDiv low", 32'(ifK1.doneDiv), 32'd0);
        check("hold divByZero", 32'(ifK1.divByZero), 32'd1);
        check("hold result", ifK1.result, 32'hFFFF_FFFF);
        check("hold readyDiv", 32'(ifK1.readyDiv), 32'd1);

        // Reset mid-op at cycle 5.
        startOp(OP_DIVU, 32'd100, 32'd7);
        for (int c = 1; c < 5; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst readyDiv", 32'(ifK1.readyDiv), 32'd1);
        check("midrst doneDiv", 32'(ifK1.doneDiv), 32'd0);
        check("midrst result", ifK1.result, 32'd0);
        check("midrst flags", {30'd0, ifK1.divByZero, ifK1.overflow}, 32'd0);
        countDone(40, n);
        check("midrst stray done", 32'(n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
